// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER pipeline front end: 2-bit predictor counter
// states and the branch-predictor table entry record.
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt2_e;

  // Tag field is sized for the smallest table; narrower tags leave upper bits zero.
  localparam int TAG_W = 30;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    cnt2_e            cnt;
    logic [31:0]      target;
  } bp_entry_t;

  localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: {TAG_W{1'b0}}, cnt: CNT_WNT, target: 32'h0000_0000};

endpackage

// File: rtl/pipe_sat_counter2.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module pipe_sat_counter2
  import otter_pipe_pkg::*;
(
  input  cnt2_e state,
  input  logic  taken,
  output cnt2_e next
);

  // Step toward strongly-taken or strongly-not-taken, holding at the ends.
  always_comb begin
    next = state;
    case (state)
      CNT_SNT: next = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: next = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  next = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  next = taken ? CNT_ST  : CNT_WT;
      default: next = CNT_WNT;
    endcase
  end

endmodule

// File: rtl/pipe_branch_predictor.sv
// Direct-mapped branch predictor with 2-bit counters and target storage,
// mispredict flush/redirect generation and saturating branch statistics.
module pipe_branch_predictor
  import otter_pipe_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);

  bp_entry_t tbl_q [ENTRIES];
  bp_entry_t tbl_d [ENTRIES];

  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic [IDX-1:0]   fetch_idx_s, upd_idx_s;
  logic [TAG_W-1:0] fetch_tag_s, upd_tag_s;
  logic             upd_hit_s, mispred_s;
  cnt2_e            cnt_next_s;

  assign fetch_idx_s = fetch_pc[IDX+1:2];
  assign fetch_tag_s = TAG_W'(fetch_pc >> (IDX + 2));
  assign upd_idx_s   = upd_pc[IDX+1:2];
  assign upd_tag_s   = TAG_W'(upd_pc >> (IDX + 2));
  assign upd_hit_s   = tbl_q[upd_idx_s].valid && (tbl_q[upd_idx_s].tag == upd_tag_s);

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = fetch_pc + 32'd4;
    if (tbl_q[fetch_idx_s].valid && (tbl_q[fetch_idx_s].tag == fetch_tag_s) &&
        tbl_q[fetch_idx_s].cnt[1]) begin
      pred_taken  = 1'b1;
      pred_target = tbl_q[fetch_idx_s].target;
    end else begin
      pred_taken  = 1'b0;
    end
  end

  pipe_sat_counter2 u_sat (
    .state (tbl_q[upd_idx_s].cnt),
    .taken (upd_taken),
    .next  (cnt_next_s)
  );

  assign mispred_s = upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_target)));

  // Table training, flush/redirect generation and statistics.
  always_comb begin
    tbl_d      = tbl_q;
    flush_d    = mispred_s;
    redirect_d = redirect_q;
    bcnt_d     = bcnt_q;
    mcnt_d     = mcnt_q;
    if (upd_valid) begin
      if (upd_hit_s) begin
        tbl_d[upd_idx_s].cnt = cnt_next_s;
        if (upd_taken) begin
          tbl_d[upd_idx_s].target = upd_target;
        end else begin
          tbl_d[upd_idx_s].target = tbl_q[upd_idx_s].target;
        end
      end else if (upd_taken) begin
        tbl_d[upd_idx_s] = '{valid: 1'b1, tag: upd_tag_s, cnt: CNT_WT, target: upd_target};
      end else begin
        tbl_d[upd_idx_s] = tbl_q[upd_idx_s];
      end
      bcnt_d = (&bcnt_q) ? bcnt_q : bcnt_q + CNT_W'(1);
    end else begin
      bcnt_d = bcnt_q;
    end
    if (mispred_s) begin
      redirect_d = upd_taken ? upd_target : upd_pc + 32'd4;
      mcnt_d     = (&mcnt_q) ? mcnt_q : mcnt_q + CNT_W'(1);
    end else begin
      redirect_d = redirect_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= ENTRY_RST;
      end
      flush_q    <= 1'b0;
      redirect_q <= 32'h0000_0000;
      bcnt_q     <= {CNT_W{1'b0}};
      mcnt_q     <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      bcnt_q     <= bcnt_d;
      mcnt_q     <= mcnt_d;
    end
  end

  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_pipe_branch_predictor.sv
// Directed-vector bench for pipe_branch_predictor (ENTRIES=16, CNT_W=16).
module tb_pipe_branch_predictor;

  logic        CLK, RST_N;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  int n_vec  = 0;
  int n_miss = 0;

  pipe_branch_predictor #(.ENTRIES(16), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .flush(flush), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic test_reset();
    step(); step();
    if (flush !== 1'b0) begin n_miss++; $display("FAIL rst_flush: got %b want 0", flush); end
    n_vec++;
    if (redirect_pc !== 32'h0) begin n_miss++; $display("FAIL rst_redirect: got %h want 0", redirect_pc); end
    n_vec++;
    if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
      n_miss++; $display("FAIL rst_counts: got %0d/%0d want 0/0", branch_count, mispredict_count);
    end
    n_vec++;
    RST_N = 1'b1;
    fetch_pc = 32'h0000_0100; #1;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0104) begin
      n_miss++; $display("FAIL rst_pred100: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    n_vec++;
    fetch_pc = 32'h0000_0000; #1;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0004) begin
      n_miss++; $display("FAIL rst_pred0: got %b/%h want 0/00000004", pred_taken, pred_target);
    end
    n_vec++;
  endtask

  task automatic test_alloc();
    upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    fetch_pc = 32'h100; #1;
    if (pred_taken !== 1'b0) begin n_miss++; $display("FAIL no_bypass: got %b want 0", pred_taken); end
    n_vec++;
    step();
    upd_valid = 1'b0;
    if (flush !== 1'b1 || redirect_pc !== 32'h200) begin
      n_miss++; $display("FAIL alloc_flush: got %b/%h want 1/00000200", flush, redirect_pc);
    end
    n_vec++;
    if (branch_count !== 16'd1 || mispredict_count !== 16'd1) begin
      n_miss++; $display("FAIL alloc_counts: got %0d/%0d want 1/1", branch_count, mispredict_count);
    end
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      n_miss++; $display("FAIL alloc_pred: got %b/%h want 1/00000200", pred_taken, pred_target);
    end
    n_vec++;
    step();
    if (flush !== 1'b0) begin n_miss++; $display("FAIL alloc_flush_drop: got %b want 0", flush); end
    n_vec++;
  endtask

  task automatic test_not_taken();
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 1'b0, 32'h0, (i == 0), (i == 0) ? 32'h200 : 32'h104);
      step();
      if (flush !== (i == 0)) begin
        n_miss++; $display("FAIL nt_flush%0d: got %b want %b", i, flush, (i == 0));
      end
      n_vec++;
      if (i == 0) begin
        if (redirect_pc !== 32'h104) begin
          n_miss++; $display("FAIL nt_redirect: got %h want 00000104", redirect_pc);
        end
        n_vec++;
      end
    end
    upd_valid = 1'b0;
    step();
    if (flush !== 1'b0) begin n_miss++; $display("FAIL nt_flush_end: got %b want 0", flush); end
    n_vec++;
    fetch_pc = 32'h100; #1;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_miss++; $display("FAIL nt_pred: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    n_vec++;
    if (branch_count !== 16'd5 || mispredict_count !== 16'd2) begin
      n_miss++; $display("FAIL nt_counts: got %0d/%0d want 5/2", branch_count, mispredict_count);
    end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] ptk;
    logic [2:0] exp_fl;
    ptk    = 3'b100;
    exp_fl = 3'b011;
    for (int i = 0; i < 3; i++) begin
      upd(32'h100, 1'b1, 32'h200, ptk[i], ptk[i] ? 32'h200 : 32'h104);
      step();
      if (flush !== exp_fl[i]) begin
        n_miss++; $display("FAIL b2b_flush%0d: got %b want %b", i, flush, exp_fl[i]);
      end
      n_vec++;
      if (exp_fl[i] && redirect_pc !== 32'h200) begin
        n_miss++; $display("FAIL b2b_redirect%0d: got %h want 00000200", i, redirect_pc);
      end
      n_vec++;
    end
    upd_valid = 1'b0;
    if (branch_count !== 16'd8 || mispredict_count !== 16'd4) begin
      n_miss++; $display("FAIL b2b_counts: got %0d/%0d want 8/4", branch_count, mispredict_count);
    end
    n_vec++;
  endtask

  task automatic test_alias();
    fetch_pc = 32'h140; #1;
    if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
      n_miss++; $display("FAIL alias_pred: got %b/%h want 0/00000144", pred_taken, pred_target);
    end
    n_vec++;
    fetch_pc = 32'h100; #1;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      n_miss++; $display("FAIL alias_owner: got %b/%h want 1/00000200", pred_taken, pred_target);
    end
    n_vec++;
    upd(32'h140, 1'b0, 32'h0, 1'b0, 32'h144);
    step();
    upd_valid = 1'b0;
    if (flush !== 1'b0) begin n_miss++; $display("FAIL alias_flush: got %b want 0", flush); end
    n_vec++;
    if (pred_taken !== 1'b1) begin n_miss++; $display("FAIL alias_untouched: got %b want 1", pred_taken); end
    n_vec++;
    if (branch_count !== 16'd9 || mispredict_count !== 16'd4) begin
      n_miss++; $display("FAIL alias_counts: got %0d/%0d want 9/4", branch_count, mispredict_count);
    end
    n_vec++;
  endtask

  task automatic test_ignore();
    upd_valid = 1'b0; upd_pc = 32'h240; upd_taken = 1'b1; upd_target = 32'h999;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    step(); step();
    if (flush !== 1'b0) begin n_miss++; $display("FAIL ign_flush: got %b want 0", flush); end
    n_vec++;
    if (branch_count !== 16'd9 || mispredict_count !== 16'd4) begin
      n_miss++; $display("FAIL ign_counts: got %0d/%0d want 9/4", branch_count, mispredict_count);
    end
    n_vec++;
    fetch_pc = 32'h240; #1;
    if (pred_taken !== 1'b0) begin n_miss++; $display("FAIL ign_alloc: got %b want 0", pred_taken); end
    n_vec++;
  endtask

  task automatic test_wrap();
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1000);
    step();
    upd_valid = 1'b0;
    if (flush !== 1'b1 || redirect_pc !== 32'h0) begin
      n_miss++; $display("FAIL wrap_redirect: got %b/%h want 1/00000000", flush, redirect_pc);
    end
    n_vec++;
    if (branch_count !== 16'd10 || mispredict_count !== 16'd5) begin
      n_miss++; $display("FAIL wrap_counts: got %0d/%0d want 10/5", branch_count, mispredict_count);
    end
    n_vec++;
    step();
    if (flush !== 1'b0) begin n_miss++; $display("FAIL wrap_flush_drop: got %b want 0", flush); end
    n_vec++;
  endtask

  task automatic test_target_mismatch();
    upd(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    step();
    upd_valid = 1'b0;
    if (flush !== 1'b1 || redirect_pc !== 32'h300) begin
      n_miss++; $display("FAIL tgt_redirect: got %b/%h want 1/00000300", flush, redirect_pc);
    end
    n_vec++;
    fetch_pc = 32'h100; #1;
    if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      n_miss++; $display("FAIL tgt_pred: got %b/%h want 1/00000300", pred_taken, pred_target);
    end
    n_vec++;
    if (branch_count !== 16'd11 || mispredict_count !== 16'd6) begin
      n_miss++; $display("FAIL tgt_counts: got %0d/%0d want 11/6", branch_count, mispredict_count);
    end
    n_vec++;
  endtask

  task automatic test_reset_midflight();
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
    #1;
    RST_N = 1'b0;
    step();
    upd_valid = 1'b0;
    if (flush !== 1'b0) begin n_miss++; $display("FAIL mid_flush: got %b want 0", flush); end
    n_vec++;
    if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
      n_miss++; $display("FAIL mid_counts: got %0d/%0d want 0/0", branch_count, mispredict_count);
    end
    n_vec++;
    RST_N = 1'b1;
    step();
    if (flush !== 1'b0) begin n_miss++; $display("FAIL mid_flush_post: got %b want 0", flush); end
    n_vec++;
    fetch_pc = 32'h100; #1;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_miss++; $display("FAIL mid_pred: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    n_vec++;
  endtask

  initial begin
    CLK = 1'b0; RST_N = 1'b0; fetch_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    test_reset();
    test_alloc();
    test_not_taken();
    test_back_to_back();
    test_alias();
    test_ignore();
    test_wrap();
    test_target_mismatch();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
